// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the single-bus CPU control unit: sequencer states,
// opcode values, ALU operation selects and the IR field bit positions.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   // Sequencer states: fetch (T0-T2), execute (T3-T6), plus idle and halted.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_T0     = 4'd1,
      S_T1     = 4'd2,
      S_T2     = 4'd3,
      S_T3     = 4'd4,
      S_T4     = 4'd5,
      S_T5     = 4'd6,
      S_T6     = 4'd7,
      S_HALTED = 4'd8
   } state_e;

   // Opcodes (IR[31:27]). Values 5'h10-5'h1F are undefined.
   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_SUB  = 5'h01;
   localparam logic [4:0] OP_AND  = 5'h02;
   localparam logic [4:0] OP_OR   = 5'h03;
   localparam logic [4:0] OP_SHR  = 5'h04;
   localparam logic [4:0] OP_SHL  = 5'h05;
   localparam logic [4:0] OP_ROR  = 5'h06;
   localparam logic [4:0] OP_ROL  = 5'h07;
   localparam logic [4:0] OP_MUL  = 5'h08;
   localparam logic [4:0] OP_DIV  = 5'h09;
   localparam logic [4:0] OP_NEG  = 5'h0A;
   localparam logic [4:0] OP_NOT  = 5'h0B;
   localparam logic [4:0] OP_MFHI = 5'h0C;
   localparam logic [4:0] OP_MFLO = 5'h0D;
   localparam logic [4:0] OP_NOP  = 5'h0E;
   localparam logic [4:0] OP_HALT = 5'h0F;

   // ALU operation selects. Ordinary ops reuse the opcode value directly;
   // INC is the PC increment used during fetch.
   localparam logic [4:0] ALU_ADD = 5'h00;
   localparam logic [4:0] ALU_INC = 5'h1F;

   // IR field positions.
   localparam int IR_OP_HI = 31;
   localparam int IR_OP_LO = 27;
   localparam int IR_RA_HI = 26;
   localparam int IR_RA_LO = 23;
   localparam int IR_RB_HI = 22;
   localparam int IR_RB_LO = 19;
   localparam int IR_RC_HI = 18;
   localparam int IR_RC_LO = 15;

   // Every opcode with the top bit set is undefined.
   function automatic logic is_illegal_op(input logic [4:0] op);
      return op[4];
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// ----------------------------------------------------------------------------
// reg_select_decoder
// Turns a 4-bit register index plus enable into a one-hot R0-R15 strobe.
//   idx_i    : register index
//   en_i     : strobe enable; all outputs are 0 when low
//   onehot_o : one-hot register strobe vector
// ----------------------------------------------------------------------------
module reg_select_decoder (
   input  logic [3:0]  idx_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Moore-style multi-cycle control unit for the single-bus CPU datapath.
// Sequences fetch/decode/execute and drives every datapath strobe from the
// current state and IR contents; also provides run/stop/halt control and a
// retired-instruction counter.
//   clock, clear         : clock and synchronous active-high reset
//   run, stop            : start request / stop at next instruction boundary
//   ir                   : current instruction register value
//   mem_ready            : memory read data valid
//   mem_req, Read        : memory read request / MDR source select
//   MDRin..LOin          : datapath register load strobes
//   PCout..LOout         : bus drive strobes
//   reg_out, reg_in      : one-hot R0-R15 bus drive / load
//   ops                  : ALU operation
//   busy, halted         : executing (T0-T6) / in HALTED
//   illegal              : sticky undefined-opcode flag
//   instr_count          : retired-instruction counter (wraps)
// ----------------------------------------------------------------------------
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic             stop,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             Read,
   output logic             MDRin,
   output logic             IRin,
   output logic             PCin,
   output logic             RYin,
   output logic             RZin,
   output logic             HIin,
   output logic             LOin,
   output logic             PCout,
   output logic             MDRout,
   output logic             RZLOout,
   output logic             RZHIout,
   output logic             HIout,
   output logic             LOout,
   output logic [15:0]      reg_out,
   output logic [15:0]      reg_in,
   output logic [4:0]       ops,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   state_e             state_q, state_d;
   logic               stop_pend_q, stop_pend_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [4:0]         op;
   logic [3:0]         ra, rb, rc;
   logic               is_alu, is_binary, is_muldiv;
   logic               ro_en, ri_en, retire;
   logic [3:0]         ro_idx;
   logic               unused_ir;

   assign op = ir[IR_OP_HI:IR_OP_LO];
   assign ra = ir[IR_RA_HI:IR_RA_LO];
   assign rb = ir[IR_RB_HI:IR_RB_LO];
   assign rc = ir[IR_RC_HI:IR_RC_LO];
   assign unused_ir = ^ir[IR_RC_LO-1:0];

   assign is_alu    = (op <= OP_NOT);
   assign is_binary = (op <= OP_DIV);
   assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= S_IDLE;
         stop_pend_q <= 1'b0;
         illegal_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
         illegal_q   <= illegal_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: every signal written here gets a default first; any path that
   // left one unassigned would infer a latch.
   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      illegal_d   = illegal_q;
      cnt_d       = cnt_q;
      mem_req     = 1'b0;
      Read        = 1'b0;
      MDRin       = 1'b0;
      IRin        = 1'b0;
      PCin        = 1'b0;
      RYin        = 1'b0;
      RZin        = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      PCout       = 1'b0;
      MDRout      = 1'b0;
      RZLOout     = 1'b0;
      RZHIout     = 1'b0;
      HIout       = 1'b0;
      LOout       = 1'b0;
      ops         = ALU_ADD;
      ro_en       = 1'b0;
      ro_idx      = rb;
      ri_en       = 1'b0;
      retire      = 1'b0;

      // A stop request anywhere inside an instruction is remembered until
      // the instruction boundary.
      if (busy && stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (run && !stop) begin
               state_d = S_T0;
            end
         end
         S_T0: begin
            PCout   = 1'b1;
            ops     = ALU_INC;
            RZin    = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            // PC+1 is reloaded every wait cycle; harmless since RZ is stable.
            RZLOout = 1'b1;
            PCin    = 1'b1;
            mem_req = 1'b1;
            Read    = 1'b1;
            MDRin   = mem_ready;
            if (mem_ready) begin
               state_d = S_T2;
            end
         end
         S_T2: begin
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            if (is_alu) begin
               ro_en   = 1'b1;
               RYin    = 1'b1;
               state_d = S_T4;
            end else if (op == OP_MFHI) begin
               HIout  = 1'b1;
               ri_en  = 1'b1;
               retire = 1'b1;
            end else if (op == OP_MFLO) begin
               LOout  = 1'b1;
               ri_en  = 1'b1;
               retire = 1'b1;
            end else if (op == OP_HALT) begin
               cnt_d       = cnt_q + CNT_W'(1);
               stop_pend_d = 1'b0;
               state_d     = S_HALTED;
            end else begin
               // nop and undefined opcodes retire with no strobes.
               if (is_illegal_op(op)) begin
                  illegal_d = 1'b1;
               end
               retire = 1'b1;
            end
         end
         S_T4: begin
            ro_en   = 1'b1;
            ro_idx  = is_binary ? rc : rb;
            ops     = op;
            RZin    = 1'b1;
            state_d = S_T5;
         end
         S_T5: begin
            RZLOout = 1'b1;
            if (is_muldiv) begin
               LOin    = 1'b1;
               state_d = S_T6;
            end else begin
               ri_en  = 1'b1;
               retire = 1'b1;
            end
         end
         S_T6: begin
            RZHIout = 1'b1;
            HIin    = 1'b1;
            retire  = 1'b1;
         end
         S_HALTED: begin
            if (run) begin
               state_d = S_T0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Instruction boundary: count it and decide whether to keep running.
      if (retire) begin
         cnt_d       = cnt_q + CNT_W'(1);
         stop_pend_d = 1'b0;
         state_d     = (stop_pend_q || stop) ? S_IDLE : S_T0;
      end
   end

   reg_select_decoder u_reg_out_dec (
      .idx_i    (ro_idx),
      .en_i     (ro_en),
      .onehot_o (reg_out)
   );

   reg_select_decoder u_reg_in_dec (
      .idx_i    (ra),
      .en_i     (ri_en),
      .onehot_o (reg_in)
   );

   assign busy        = (state_q >= S_T0) && (state_q <= S_T6);
   assign halted      = (state_q == S_HALTED);
   assign illegal     = illegal_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   localparam int CW = 4;

   logic          clock, clear, run, stop, mem_ready;
   logic [31:0]   ir;
   logic          mem_req, Read, MDRin, IRin, PCin, RYin, RZin, HIin, LOin;
   logic          PCout, MDRout, RZLOout, RZHIout, HIout, LOout;
   logic [15:0]   reg_out, reg_in;
   logic [4:0]    ops;
   logic          busy, halted, illegal;
   logic [CW-1:0] instr_count;

   control_sequencer #(.CNT_W(CW)) dut (
      .clock(clock), .clear(clear), .run(run), .stop(stop), .ir(ir),
      .mem_ready(mem_ready), .mem_req(mem_req), .Read(Read), .MDRin(MDRin),
      .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .HIin(HIin),
      .LOin(LOin), .PCout(PCout), .MDRout(MDRout), .RZLOout(RZLOout),
      .RZHIout(RZHIout), .HIout(HIout), .LOout(LOout), .reg_out(reg_out),
      .reg_in(reg_in), .ops(ops), .busy(busy), .halted(halted),
      .illegal(illegal), .instr_count(instr_count)
   );

   typedef struct packed {
      logic mem_req, rd, mdrin, irin, pcin, ryin, rzin, hiin, loin;
      logic pcout, mdrout, rzlo, rzhi, hiout, loout;
      logic [15:0] rout, rin;
      logic [4:0]  ops;
      logic busy, halted;
   } outs_t;

   typedef enum {M_IDLE, M_RUN, M_HALTED} mode_e;

   outs_t obs;
   assign obs = {mem_req, Read, MDRin, IRin, PCin, RYin, RZin, HIin, LOin,
                 PCout, MDRout, RZLOout, RZHIout, HIout, LOout,
                 reg_out, reg_in, ops, busy, halted};

   int    checks = 0, passed = 0, fails = 0;
   int    cnt_m  = 0;
   logic  ill_m  = 1'b0;
   mode_e mode   = M_IDLE;
   logic [31:0] prev_ir = '0;
   outs_t exp_q[$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   // One clock cycle: inputs already driven at the falling edge; compare,
   // then advance to the next falling edge.
   task automatic cycle(input outs_t e, input string tag);
      logic [63:0] ov, ev;
      #1;
      ov = '0; ov[$bits(outs_t)-1:0] = obs;
      ev = '0; ev[$bits(outs_t)-1:0] = e;
      check({tag, " strobes"}, ov, ev);
      check({tag, " count"}, 64'(instr_count), 64'(cnt_m[CW-1:0]));
      check({tag, " illegal"}, 64'(illegal), 64'(ill_m));
      @(negedge clock);
   endtask

   function automatic outs_t rest_rec();
      outs_t o;
      o = '0;
      o.halted = (mode == M_HALTED);
      return o;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, from the
   // microstep table: fetch, then the execute steps for the opcode class.
   task automatic build(input logic [31:0] instr, input int waits);
      outs_t o;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
      exp_q.delete();
      o = '0; o.busy = 1; o.pcout = 1; o.ops = 5'h1F; o.rzin = 1; exp_q.push_back(o);
      for (int w = 0; w <= waits; w++) begin
         o = '0; o.busy = 1; o.rzlo = 1; o.pcin = 1; o.mem_req = 1; o.rd = 1;
         o.mdrin = (w == waits);
         exp_q.push_back(o);
      end
      o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1; exp_q.push_back(o);
      o = '0; o.busy = 1;
      if (op <= 5'h0B) begin
         o.rout = 16'(1) << rb; o.ryin = 1; exp_q.push_back(o);
         o = '0; o.busy = 1; o.ops = op; o.rzin = 1;
         o.rout = 16'(1) << ((op <= 5'h09) ? rc : rb);
         exp_q.push_back(o);
         o = '0; o.busy = 1; o.rzlo = 1;
         if (op == 5'h08 || op == 5'h09) begin
            o.loin = 1; exp_q.push_back(o);
            o = '0; o.busy = 1; o.rzhi = 1; o.hiin = 1; exp_q.push_back(o);
         end else begin
            o.rin = 16'(1) << ra; exp_q.push_back(o);
         end
      end else if (op == 5'h0C) begin
         o.hiout = 1; o.rin = 16'(1) << ra; exp_q.push_back(o);
      end else if (op == 5'h0D) begin
         o.loout = 1; o.rin = 16'(1) << ra; exp_q.push_back(o);
      end else begin
         exp_q.push_back(o);
      end
   endtask

   task automatic rest_cycle(input logic r, input logic s, input string tag);
      run = r; stop = s; clear = 0; mem_ready = 1'($urandom); ir = prev_ir;
      cycle(rest_rec(), tag);
      if (r && (mode == M_HALTED || !s)) mode = M_RUN;
   endtask

   // Runs one instruction. stop_at / clear_at: trace index at which to pulse
   // stop / clear (-1 for none).
   task automatic run_instr(input logic [31:0] instr, input int waits,
                            input int stop_at, input int clear_at, input string tag);
      int n;
      if (mode != M_RUN) rest_cycle(1'b1, 1'b0, {tag, " start"});
      build(instr, waits);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         run = 0; stop = (i == stop_at); clear = (i == clear_at);
         ir = (i >= waits + 3) ? instr : prev_ir;
         if (i >= 1 && i <= waits) mem_ready = 1'b0;
         else if (i == waits + 1)  mem_ready = 1'b1;
         else                      mem_ready = 1'($urandom);
         cycle(exp_q[i], $sformatf("%s c%0d", tag, i));
         if (i == clear_at) begin
            cnt_m = 0; ill_m = 0; mode = M_IDLE; prev_ir = instr; clear = 0;
            return;
         end
      end
      prev_ir = instr;
      cnt_m = (cnt_m + 1) % (1 << CW);
      if (instr[31]) ill_m = 1'b1;
      if (instr[31:27] == 5'h0F) mode = M_HALTED;
      else if (stop_at >= 0)     mode = M_IDLE;
      else                       mode = M_RUN;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'h0};
   endfunction

   initial begin
      clear = 1; run = 0; stop = 0; mem_ready = 0; ir = '0;
      repeat (2) @(negedge clock);
      rest_cycle(0, 0, "reset");
      rest_cycle(0, 0, "reset2");

      run_instr(mk(5'h00, 4'd3, 4'd1, 4'd2), 0, -1, -1, "add");
      run_instr(mk(5'h00, 4'd7, 4'd4, 4'd9), 3, -1, -1, "add_wait");
      run_instr(mk(5'h08, 4'd0, 4'd5, 4'd6), 0, -1, -1, "mul");
      run_instr(mk(5'h0F, 4'd0, 4'd0, 4'd0), 1, -1, -1, "halt");
      rest_cycle(0, 0, "halted");
      run_instr(mk(5'h01, 4'd2, 4'd8, 4'd15), 0, 4, -1, "sub_stop");
      rest_cycle(0, 0, "stopped");
      run_instr(mk(5'h15, 4'd4, 4'd4, 4'd4), 0, -1, -1, "illegal");
      run_instr(mk(5'h0C, 4'd11, 4'd0, 4'd0), 2, -1, -1, "mfhi");
      run_instr(mk(5'h0D, 4'd12, 4'd0, 4'd0), 0, -1, -1, "mflo");
      run_instr(mk(5'h0B, 4'd1, 4'd14, 4'd3), 0, -1, -1, "not");
      run_instr(mk(5'h09, 4'd1, 4'd10, 4'd13), 0, -1, -1, "div");
      run_instr(mk(5'h0E, 4'd0, 4'd0, 4'd0), 0, 1, -1, "nop_stop");
      rest_cycle(1, 1, "run_and_stop");
      rest_cycle(0, 0, "still_idle");
      run_instr(mk(5'h00, 4'd3, 4'd1, 4'd2), 0, -1, 4, "add_clear");
      rest_cycle(0, 0, "after_clear");
      run_instr(mk(5'h02, 4'd3, 4'd1, 4'd2), 3, -1, 2, "wait_clear");
      rest_cycle(0, 0, "after_clear2");

      for (int k = 0; k < 40; k++) begin
         logic [31:0] ins;
         int w, s;
         ins = mk(5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom), 4'($urandom));
         w = $urandom_range(0, 3);
         s = -1;
         if (ins[31:27] != 5'h0F && $urandom_range(0, 3) == 0) begin
            build(ins, w);
            s = $urandom_range(0, exp_q.size() - 2);
         end
         run_instr(ins, w, s, -1, $sformatf("rnd%0d", k));
         if (mode != M_RUN) rest_cycle(0, 0, $sformatf("rnd%0d rest", k));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the single-bus CPU datapath. It runs fetch, decode and execute as a Moore state machine and drives the datapath's register out/in strobes, ALU op select, RY/RZ latches and memory read handshake from the current state and the IR contents. It also provides run/stop/halt control and a retired-instruction counter. It sits beside the datapath at CPU top level and is the only source of datapath strobes.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  sole clock; all state changes on rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `run`  in  1  start request, honoured in IDLE or HALTED.
- `stop`  in  1  request to stop at the next instruction boundary.
- `ir`  in  32  current IR value; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `mem_ready`  in  1  memory read data valid this cycle.
- `mem_req`  out  1  memory read request.
- `Read`  out  1  MDR source select: memory.
- `MDRin`, `IRin`, `PCin`, `RYin`, `RZin`, `HIin`, `LOin`  out  1 each  datapath register load strobes.
- `PCout`, `MDRout`, `RZLOout`, `RZHIout`, `HIout`, `LOout`  out  1 each  bus drive strobes.
- `reg_out`  out  16  one-hot R0–R15 bus drive.
- `reg_in`  out  16  one-hot R0–R15 load.
- `ops`  out  5  ALU operation.
- `busy`  out  1  high in T0–T6.
- `halted`  out  1  high in HALTED.
- `illegal`  out  1  sticky; set when an undefined opcode is decoded.
- `instr_count`  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED. Strobes are a combinational decode of the state register and `ir`. At most one bus driver is active per cycle.
- IDLE: all strobes 0. `run`=1 and `stop`=0 moves to T0. If `run` and `stop` are both 1, the block stays in IDLE.
- T0: PCout, ops=INC (5'h1F), RZin.
- T1: RZLOout, PCin, mem_req, Read. MDRin is asserted only when `mem_ready`=1. The state holds in T1 until `mem_ready`. Repeated PCin reloads the same PC+1, so a wait is harmless.
- T2: MDRout, IRin. The next state is taken from the new `ir` opcode in T3.
- Opcodes: 00 add, 01 sub, 02 and, 03 or, 04 shr, 05 shl, 06 ror, 07 rol, 08 mul, 09 div, 0A neg, 0B not, 0C mfhi, 0D mflo, 0E nop, 0F halt. 10–1F are illegal.
- Binary ops 00–09 and unary ops 0A–0B:
  - T3: reg_out[Rb], RYin.
  - T4: reg_out[Rc] for binary or reg_out[Rb] for unary, ops=opcode, RZin.
  - T5: RZLOout. Non-mul/div ops also assert reg_in[Ra] and retire. mul/div assert LOin instead.
  - T6 (mul/div only): RZHIout, HIin, retire.
- mfhi/mflo: T3 asserts HIout or LOout plus reg_in[Ra], then retires.
- nop and illegal opcodes: retire in T3 with no strobes. An illegal opcode also sets `illegal`.
- halt: in T3 the state goes to HALTED and `instr_count` increments. `run` in HALTED goes to T0.
- Retire: `instr_count` increments by 1 (wrapping from all-ones to 0). Next state is IDLE if `stop` was seen since T0 (latched `stop_pend`), else T0. `stop_pend` clears on retire.

## Timing
- Reset: on `clear`, state=IDLE and `stop_pend`=0, `illegal`=0, `instr_count`=0. All strobes, `mem_req`, `busy` and `halted` are 0 the cycle after. `clear` wins over every other input, including mid-instruction and during a T1 wait.
- Latency with `mem_ready` in the first T1 cycle: ALU op 6 cycles, mul/div 7, mfhi/mflo/nop/halt 4. Each extra memory wait cycle adds 1.
- `mem_ready` outside T1 is ignored.
- `ir` is sampled combinationally in T3–T6. It is stable because IRin is asserted only in T2.

## Structure
- `cpu_ctrl_pkg`: state enum, opcode constants, ALU op constants including INC=5'h1F, IR field bit positions.
- Sub-module `reg_select_decoder`: 4-bit index plus enable to a 16-bit one-hot vector. It is instantiated twice, once for `reg_out` and once for `reg_in`.

## Test plan
- Reset mid-instruction: assert `clear` in T4 of an add → next cycle IDLE, every output 0, `instr_count`=0.
- add R3,R1,R2 with `mem_ready` in the first T1 cycle → T3 reg_out=16'h0002, T4 reg_out=16'h0004 with ops=0, T5 reg_in=16'h0008; 6 cycles; `instr_count` +1.
- Memory wait: hold `mem_ready` low for 3 cycles → T1 held 4 cycles, MDRin asserted only in the 4th, IRin exactly once.
- mul R5,R6 → T5 RZLOout+LOin, T6 RZHIout+HIin, reg_in=0 throughout; 7 cycles.
- halt → HALTED, `halted`=1, `busy`=0; then `run` pulse → T0 next cycle.
- Pulse `stop` during T4 of an op → completes T5 then IDLE. Opcode 5'h15 → `illegal`=1 stays set, no reg_in strobe, `instr_count` still increments.
